// File: rtl/fp_fma_sat_if.sv
// fp_fma_sat_if: transaction bundle for the saturating fused multiply-add.
// The master drives operands and the acknowledge; the slave returns the result.
interface fp_fma_sat_if #(
    parameter int in_ibits  = 12,
    parameter int in_fbits  = 20,
    parameter int out_ibits = 12,
    parameter int out_fbits = 20,
    parameter int id_bits   = 8
);
    localparam int n = in_ibits + in_fbits;
    localparam int m = out_ibits + out_fbits;
    logic [n-1:0]       a;
    logic [n-1:0]       b;
    logic [2*n-1:0]     c;
    logic [1:0]         op;
    logic [id_bits-1:0] iid;
    logic               ivalid;
    logic               iready;
    logic [m-1:0]       r;
    logic               ovf;
    logic [id_bits-1:0] oid;
    logic               ovalid;
    logic               oacknowledge;
    modport master (output a, b, c, op, iid, ivalid, oacknowledge, input iready, r, ovf, oid, ovalid);
    modport slave (input a, b, c, op, iid, ivalid, oacknowledge, output iready, r, ovf, oid, ovalid);
endinterface

// File: rtl/fp_fma_sat.sv
// fp_fma_sat: stallable pipelined +-(a*b)+-c with rounding, saturation and id passthrough.
// One global advance enable moves every stage; the sum is formed once and then delayed.
module fp_fma_sat #(
    parameter int   in_ibits      = 12,
    parameter int   in_fbits      = 20,
    parameter int   out_ibits     = 12,
    parameter int   out_fbits     = 20,
    parameter int   id_bits       = 8,
    parameter int   latency       = 4,
    parameter logic round_nearest = 1'b1
) (
    input logic         clock,
    input logic         reset,
    fp_fma_sat_if.slave bus
);
    localparam int n   = in_ibits + in_fbits;
    localparam int n2  = 2 * n;
    localparam int m   = out_ibits + out_fbits;
    localparam int w   = n2 + 2;
    localparam int x   = w + m + 1;
    localparam int sh  = 2 * in_fbits - out_fbits;
    localparam int dly = latency - 2;
    localparam logic signed [w-1:0] rnd = (round_nearest && sh > 0) ? (w'(1) <<< (sh > 0 ? sh - 1 : 0)) : '0;
    localparam logic signed [x-1:0] qmax = (x'(1) <<< (m - 1)) - x'(1);
    localparam logic signed [x-1:0] qmin = -(x'(1) <<< (m - 1));

    logic                      advance;
    logic                      v1;
    logic signed [n-1:0]       a1;
    logic signed [n-1:0]       b1;
    logic signed [n2-1:0]      c1;
    logic [1:0]                op1;
    logic [id_bits-1:0]        id1;
    logic [dly-1:0]            vd;
    logic signed [w-1:0]       sd [dly];
    logic [id_bits-1:0]        idd [dly];
    logic signed [n2-1:0]      p;
    logic signed [w-1:0]       pw;
    logic signed [w-1:0]       cw;
    logic signed [w-1:0]       s;
    logic signed [w-1:0]       sr;
    logic signed [w-1:0]       q;
    logic signed [x-1:0]       qx;
    logic                      ovf_n;
    logic [m-1:0]              r_n;

    assign advance    = !bus.ovalid || bus.oacknowledge;
    assign bus.iready = reset && advance;
    assign p  = n2'(a1) * n2'(b1);
    assign pw = {{2{p[n2-1]}}, p};
    assign cw = {{2{c1[n2-1]}}, c1};
    assign s  = (op1[0] ? -pw : pw) + (op1[1] ? -cw : cw);
    // rounding and saturation are applied on the last delayed sum, just ahead of the output flops
    assign sr = sd[dly-1] + rnd;
    assign q  = sr >>> sh;
    assign qx = {{(x-w){q[w-1]}}, q};
    assign ovf_n = (qx > qmax) || (qx < qmin);
    assign r_n   = qx > qmax ? qmax[m-1:0] : qx < qmin ? qmin[m-1:0] : qx[m-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1         <= 1'b0;
            vd         <= '0;
            bus.ovalid <= 1'b0;
            bus.r      <= '0;
            bus.ovf    <= 1'b0;
            bus.oid    <= '0;
        end else if (advance) begin
            v1         <= bus.ivalid;
            vd[0]      <= v1;
            for (int k = 1; k < dly; k++) vd[k] <= vd[k-1];
            bus.ovalid <= vd[dly-1];
            bus.r      <= r_n;
            bus.ovf    <= ovf_n;
            bus.oid    <= idd[dly-1];
        end
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            a1     <= bus.a;
            b1     <= bus.b;
            c1     <= bus.c;
            op1    <= bus.op;
            id1    <= bus.iid;
            sd[0]  <= s;
            idd[0] <= id1;
            for (int k = 1; k < dly; k++) begin
                sd[k]  <= sd[k-1];
                idd[k] <= idd[k-1];
            end
        end
    end
endmodule

// File: tb/tb_fp_fma_sat.sv
// tb_fp_fma_sat: directed and randomized checks of fp_fma_sat against a wide-integer model.
// Small Q4.4 instances (nearest and truncate) share stimulus; a default-parameter instance covers wide formats.
module tb_fp_fma_sat;
    logic clock = 0;
    logic reset = 1;
    int   checks = 0;
    int   errors = 0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] r;
        logic       ovf;
        logic [7:0] id;
        logic [7:0] rt;
        logic       ovft;
    } exp_t;

    fp_fma_sat_if #(.in_ibits(4), .in_fbits(4), .out_ibits(4), .out_fbits(4), .id_bits(8)) if_s ();
    fp_fma_sat_if #(.in_ibits(4), .in_fbits(4), .out_ibits(4), .out_fbits(4), .id_bits(8)) if_t ();
    fp_fma_sat_if if_w ();

    fp_fma_sat #(.in_ibits(4), .in_fbits(4), .out_ibits(4), .out_fbits(4), .id_bits(8), .latency(3), .round_nearest(1'b1))
        u_s (.clock(clock), .reset(reset), .bus(if_s.slave));
    fp_fma_sat #(.in_ibits(4), .in_fbits(4), .out_ibits(4), .out_fbits(4), .id_bits(8), .latency(3), .round_nearest(1'b0))
        u_t (.clock(clock), .reset(reset), .bus(if_t.slave));
    fp_fma_sat u_w (.clock(clock), .reset(reset), .bus(if_w.slave));

    assign if_t.a            = if_s.a;
    assign if_t.b            = if_s.b;
    assign if_t.c            = if_s.c;
    assign if_t.op           = if_s.op;
    assign if_t.iid          = if_s.iid;
    assign if_t.ivalid       = if_s.ivalid;
    assign if_t.oacknowledge = if_s.oacknowledge;

    // exact reference: plain integer arithmetic, floor-shift rounding, clamp to M bits
    function automatic void model(input logic signed [127:0] a, b, c, input logic [1:0] op, input int sh, m, rn,
                                  output logic signed [127:0] r, output logic ovf);
        logic signed [127:0] s, q, mx, mn;
        s  = (op[0] ? -(a * b) : a * b) + (op[1] ? -c : c);
        q  = (s + ((rn != 0 && sh > 0) ? (128'sd1 <<< (sh - 1)) : 128'sd0)) >>> sh;
        mx = (128'sd1 <<< (m - 1)) - 128'sd1;
        mn = -(128'sd1 <<< (m - 1));
        ovf = (q > mx) || (q < mn);
        r = q > mx ? mx : q < mn ? mn : q;
    endfunction

    function automatic exp_t expect_small(input logic [7:0] a, b, input logic [15:0] c, input logic [1:0] op, input logic [7:0] id);
        logic signed [127:0] rr, rt;
        logic o, ot;
        model(128'(signed'(a)), 128'(signed'(b)), 128'(signed'(c)), op, 4, 8, 1, rr, o);
        model(128'(signed'(a)), 128'(signed'(b)), 128'(signed'(c)), op, 4, 8, 0, rt, ot);
        return '{r: rr[7:0], ovf: o, id: id, rt: rt[7:0], ovft: ot};
    endfunction

    task automatic run_one(input logic [7:0] a, b, input logic [15:0] c, input logic [1:0] op, input logic [7:0] id,
                           output logic [7:0] r, output logic ovf, output logic [7:0] oid, output logic [7:0] rt, output int lat);
        @(negedge clock);
        if_s.a = a; if_s.b = b; if_s.c = c; if_s.op = op; if_s.iid = id;
        if_s.ivalid = 1; if_s.oacknowledge = 1;
        @(posedge clock);
        #1 if_s.ivalid = 0;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clock);
            if (if_s.ovalid) lat = i;
        end
        r = if_s.r; ovf = if_s.ovf; oid = if_s.oid; rt = if_t.r;
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #2;
        checks++; if (if_s.ovalid !== 1'b0) begin errors++; $display("FAIL rst_ovalid got %b want 0", if_s.ovalid); end
        checks++; if (if_s.r !== 8'h00) begin errors++; $display("FAIL rst_r got %h want 00", if_s.r); end
        checks++; if (if_s.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", if_s.ovf); end
        checks++; if (if_s.oid !== 8'h00) begin errors++; $display("FAIL rst_oid got %h want 00", if_s.oid); end
        checks++; if (if_s.iready !== 1'b0) begin errors++; $display("FAIL rst_iready got %b want 0", if_s.iready); end
        @(negedge clock); @(negedge clock);
        reset = 1;
        #1;
        checks++; if (if_s.iready !== 1'b1) begin errors++; $display("FAIL rst_release_iready got %b want 1", if_s.iready); end
    endtask

    task automatic test_basic();
        logic [7:0] r, oid, rt;
        logic ovf;
        int lat;
        run_one(8'h18, 8'h20, 16'h0040, 2'b00, 8'h5A, r, ovf, oid, rt, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
        checks++; if (r !== 8'h34) begin errors++; $display("FAIL basic_r got %h want 34", r); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
        checks++; if (oid !== 8'h5A) begin errors++; $display("FAIL basic_oid got %h want 5a", oid); end
        run_one(8'h18, 8'h20, 16'h0040, 2'b01, 8'h5B, r, ovf, oid, rt, lat);
        checks++; if (r !== 8'hD4) begin errors++; $display("FAIL basic_negp_r got %h want d4", r); end
        run_one(8'h18, 8'h20, 16'h0040, 2'b10, 8'h5C, r, ovf, oid, rt, lat);
        checks++; if (r !== 8'h2C) begin errors++; $display("FAIL basic_negc_r got %h want 2c", r); end
    endtask

    task automatic test_rounding();
        logic [7:0] r, oid, rt;
        logic ovf;
        int lat;
        run_one(8'h01, 8'h08, 16'h0000, 2'b00, 8'h10, r, ovf, oid, rt, lat);
        checks++; if (r !== 8'h01) begin errors++; $display("FAIL round_pos_near got %h want 01", r); end
        checks++; if (rt !== 8'h00) begin errors++; $display("FAIL round_pos_trunc got %h want 00", rt); end
        run_one(8'hFF, 8'h08, 16'h0000, 2'b00, 8'h11, r, ovf, oid, rt, lat);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL round_neg_near got %h want 00", r); end
        checks++; if (rt !== 8'hFF) begin errors++; $display("FAIL round_neg_trunc got %h want ff", rt); end
    endtask

    task automatic test_saturation();
        logic [7:0] r, oid, rt;
        logic ovf;
        int lat;
        logic [7:0]  sa [5] = '{8'h70, 8'h80, 8'h80, 8'h80, 8'h10};
        logic [7:0]  sb [5] = '{8'h70, 8'h70, 8'h80, 8'h80, 8'h10};
        logic [15:0] sc [5] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0700};
        logic [1:0]  so [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [7:0]  sr [5] = '{8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
        for (int k = 0; k < 5; k++) begin
            run_one(sa[k], sb[k], sc[k], so[k], 8'(8'h20 + k), r, ovf, oid, rt, lat);
            checks++; if (r !== sr[k] || ovf !== 1'b1) begin errors++; $display("FAIL sat_%0d got r=%h ovf=%b want r=%h ovf=1", k, r, ovf, sr[k]); end
        end
        run_one(8'h18, 8'h20, 16'h0040, 2'b00, 8'h30, r, ovf, oid, rt, lat);
        checks++; if (r !== 8'h34 || ovf !== 1'b0) begin errors++; $display("FAIL sat_clear got r=%h ovf=%b want r=34 ovf=0", r, ovf); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e, got;
        int sent = 0, recv = 0, stalls = 0, cyc = 0;
        logic seen = 0, stall;
        logic [7:0] hr = 0, hid = 0;
        while (recv < 10 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (if_s.ovalid) seen = 1;
            stall = seen && stalls < 5;
            if (stall) begin
                if (stalls > 0) begin
                    checks++; if (if_s.r !== hr || if_s.oid !== hid) begin errors++; $display("FAIL bp_hold got r=%h id=%h want r=%h id=%h", if_s.r, if_s.oid, hr, hid); end
                end
                hr = if_s.r; hid = if_s.oid; stalls++;
            end
            if_s.oacknowledge = !stall;
            if_s.ivalid = sent < 10;
            if_s.a = 8'($urandom); if_s.b = 8'($urandom); if_s.c = 16'($urandom); if_s.op = 2'($urandom);
            if_s.iid = 8'(sent);
            #1;
            if (stall) begin
                checks++; if (if_s.iready !== 1'b0) begin errors++; $display("FAIL bp_iready got %b want 0", if_s.iready); end
            end
            if (if_s.ivalid && if_s.iready) begin
                q.push_back(expect_small(if_s.a, if_s.b, if_s.c, if_s.op, if_s.iid));
                sent++;
            end
            if (if_s.ovalid && if_s.oacknowledge) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL bp_extra got id=%h want none", if_s.oid); end
                else begin
                    e = q.pop_front();
                    got = '{r: if_s.r, ovf: if_s.ovf, id: if_s.oid, rt: if_t.r, ovft: if_t.ovf};
                    if (got !== e) begin errors++; $display("FAIL bp_data got %h want %h", got, e); end
                end
                recv++;
            end
        end
        if_s.ivalid = 0; if_s.oacknowledge = 1;
        checks++; if (sent != 10 || recv != 10 || q.size() != 0 || stalls != 5) begin errors++; $display("FAIL bp_count got sent=%0d recv=%0d left=%0d stalls=%0d want 10 10 0 5", sent, recv, q.size(), stalls); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r, oid, rt;
        logic ovf;
        int lat, seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if_s.a = 8'h18; if_s.b = 8'h20; if_s.c = 16'h0040; if_s.op = 0; if_s.iid = 8'(8'hA0 + k);
            if_s.ivalid = 1; if_s.oacknowledge = 1;
        end
        @(posedge clock);
        #2 reset = 0; if_s.ivalid = 0;
        #1;
        checks++; if (if_s.ovalid !== 1'b0 || if_s.r !== 8'h00 || if_s.ovf !== 1'b0 || if_s.oid !== 8'h00)
            begin errors++; $display("FAIL midrst_clear got v=%b r=%h ovf=%b id=%h want 0 00 0 00", if_s.ovalid, if_s.r, if_s.ovf, if_s.oid); end
        checks++; if (if_s.iready !== 1'b0) begin errors++; $display("FAIL midrst_iready got %b want 0", if_s.iready); end
        @(negedge clock); @(negedge clock);
        reset = 1;
        repeat (6) begin
            @(negedge clock);
            if (if_s.ovalid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_ghost got %0d outputs want 0", seen); end
        run_one(8'h18, 8'h20, 16'h0040, 2'b00, 8'h77, r, ovf, oid, rt, lat);
        checks++; if (lat != 3 || oid !== 8'h77 || r !== 8'h34) begin errors++; $display("FAIL midrst_new got lat=%0d id=%h r=%h want 3 77 34", lat, oid, r); end
    endtask

    task automatic test_wide();
        logic [31:0] wa [2] = '{32'h80000000, 32'h00100000};
        logic [63:0] wc [2] = '{64'h0, 64'h0000_0080_0000_0000};
        logic [31:0] wr [2] = '{32'h7FFFFFFF, 32'h00180000};
        logic        wo [2] = '{1'b1, 1'b0};
        int lat;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if_w.a = wa[k]; if_w.b = wa[k]; if_w.c = wc[k]; if_w.op = 0; if_w.iid = 8'(k); if_w.ivalid = 1; if_w.oacknowledge = 1;
            @(posedge clock);
            #1 if_w.ivalid = 0;
            lat = -1;
            for (int i = 1; i <= 20 && lat < 0; i++) begin
                @(negedge clock);
                if (if_w.ovalid) lat = i;
            end
            checks++; if (lat != 4 || if_w.r !== wr[k] || if_w.ovf !== wo[k])
                begin errors++; $display("FAIL wide_%0d got lat=%0d r=%h ovf=%b want 4 %h %b", k, lat, if_w.r, if_w.ovf, wr[k], wo[k]); end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e, got;
        int sent = 0, recv = 0, cyc = 0;
        logic ps = 0, po = 0;
        logic [7:0] pr = 0, pid = 0;
        while (recv < 10000 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            if (ps) begin
                checks++; if ({if_s.ovalid, if_s.r, if_s.ovf, if_s.oid} !== {1'b1, pr, po, pid})
                    begin errors++; $display("FAIL rnd_hold got v=%b r=%h ovf=%b id=%h want 1 %h %b %h", if_s.ovalid, if_s.r, if_s.ovf, if_s.oid, pr, po, pid); end
            end
            if_s.oacknowledge = $urandom_range(9) < 7;
            if_s.ivalid = sent < 10000 && $urandom_range(9) < 7;
            if_s.a = 8'($urandom); if_s.b = 8'($urandom); if_s.c = 16'($urandom); if_s.op = 2'($urandom);
            if_s.iid = 8'(sent);
            #1;
            checks++; if (if_s.iready !== (!if_s.ovalid || if_s.oacknowledge)) begin errors++; $display("FAIL rnd_iready got %b want %b", if_s.iready, !if_s.ovalid || if_s.oacknowledge); end
            if (if_s.ivalid && if_s.iready) begin
                q.push_back(expect_small(if_s.a, if_s.b, if_s.c, if_s.op, if_s.iid));
                sent++;
            end
            if (if_s.ovalid && if_s.oacknowledge) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL rnd_extra got id=%h want none", if_s.oid); end
                else begin
                    e = q.pop_front();
                    got = '{r: if_s.r, ovf: if_s.ovf, id: if_s.oid, rt: if_t.r, ovft: if_t.ovf};
                    if (got !== e) begin errors++; $display("FAIL rnd_data got %h want %h", got, e); end
                end
                recv++;
            end
            ps = if_s.ovalid && !if_s.oacknowledge;
            pr = if_s.r; po = if_s.ovf; pid = if_s.oid;
        end
        if_s.ivalid = 0; if_s.oacknowledge = 1;
        checks++; if (sent != 10000 || recv != 10000 || q.size() != 0) begin errors++; $display("FAIL rnd_count got sent=%0d recv=%0d left=%0d want 10000 10000 0", sent, recv, q.size()); end
    endtask

    initial begin
        if_s.a = 0; if_s.b = 0; if_s.c = 0; if_s.op = 0; if_s.iid = 0; if_s.ivalid = 0; if_s.oacknowledge = 1;
        if_w.a = 0; if_w.b = 0; if_w.c = 0; if_w.op = 0; if_w.iid = 0; if_w.ivalid = 0; if_w.oacknowledge = 1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
